// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, op classes, immediate formats,
// the registered decode bundle and source-register usage helpers.
package riscv_pkg;

    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_I_ALU  = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;

    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_ALU_R   = 4'd1,
        OP_ALU_I   = 4'd2,
        OP_LOAD    = 4'd3,
        OP_STORE   = 4'd4,
        OP_BRANCH  = 4'd5,
        OP_JAL     = 4'd6,
        OP_JALR    = 4'd7,
        OP_LUI     = 4'd8,
        OP_AUIPC   = 4'd9,
        OP_SYSTEM  = 4'd10,
        OP_ILLEGAL = 4'd11
    } op_class_t;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    // One decoded instruction as handed to execute. All-zero is a bubble (OP_NOP = 0).
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        op_class_t   op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7_b5;
        logic [31:0] imm;
        logic        illegal;
    } dec_out_t;

    localparam dec_out_t DEC_BUBBLE = '0;

    // rs1 is a real operand for R/I/S/B formats and JALR (SYSTEM reads it for CSR ops).
    function automatic logic uses_rs1(op_class_t op);
        return op inside {OP_ALU_R, OP_ALU_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_SYSTEM};
    endfunction

    // rs2 only carries an operand for R, S and B formats; in I-type it is immediate bits.
    function automatic logic uses_rs2(op_class_t op);
        return op inside {OP_ALU_R, OP_STORE, OP_BRANCH};
    endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch->decode->execute bundle. master = upstream/environment side driving the
// instruction and control; slave = the decode stage.
interface decode_if;
    import riscv_pkg::*;

    logic [31:0] i_instruction;
    logic [31:0] i_pc;
    logic        i_pipeline_stall;
    logic        i_flush;

    logic        o_fetch_stall;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic        o_valid;
    logic [31:0] o_pc;
    op_class_t   o_op;
    logic [4:0]  o_rd;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [2:0]  o_funct3;
    logic        o_funct7_b5;
    logic [31:0] o_imm;
    logic        o_illegal;

    // Handshake: there is no valid/ready pair here; o_valid qualifies the registered
    // bundle, and o_fetch_stall is the only back-pressure (fetch must hold its
    // instruction/PC while it is high). i_pipeline_stall freezes this stage.
    modport master (
        output i_instruction, i_pc, i_pipeline_stall, i_flush,
        input  o_fetch_stall, o_rs1_addr, o_rs2_addr, o_valid, o_pc, o_op, o_rd,
               o_rs1, o_rs2, o_funct3, o_funct7_b5, o_imm, o_illegal
    );

    modport slave (
        input  i_instruction, i_pc, i_pipeline_stall, i_flush,
        output o_fetch_stall, o_rs1_addr, o_rs2_addr, o_valid, o_pc, o_op, o_rd,
               o_rs1, o_rs2, o_funct3, o_funct7_b5, o_imm, o_illegal
    );

endinterface

// File: rtl/imm_gen.sv
// Combinational immediate builder for all RISC-V formats. The opcode bits are not
// needed, so only instr[31:7] is taken. R-type yields zero.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7] instr_i,
    input  fmt_t        fmt_i,
    output logic [31:0] imm_o
);

    // Select and sign-extend the immediate for the given format.
    always_comb begin
        imm_o = 32'd0;
        case (fmt_i)
            FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: imm_o = {instr_i[31:12], 12'd0};
            FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// Decode pipeline stage: classifies the incoming instruction, extracts fields,
// builds the immediate, detects load-use hazards and registers one bundle for execute.
module decode
    import riscv_pkg::*;
#(
    parameter bit HAZARD_DETECT = 1'b1,
    parameter bit DECODE_SYSTEM = 1'b1
) (
    input logic     clk,
    input logic     reset,
    decode_if.slave bus
);

    logic [31:0] instr;
    fmt_t        fmt;
    logic [31:0] imm;
    dec_out_t    dec_core;
    dec_out_t    dec_full;
    dec_out_t    out_d;
    dec_out_t    out_q;
    logic        hazard;

    assign instr = bus.i_instruction;

    // Register-file read addresses track the raw input so read data aligns with the next edge.
    assign bus.o_rs1_addr = instr[19:15];
    assign bus.o_rs2_addr = instr[24:20];

    // Classify opcode, pick immediate format and extract fields; zero word is a bubble.
    always_comb begin
        dec_core = DEC_BUBBLE;
        fmt      = FMT_R;
        if (instr != 32'd0) begin
            dec_core.valid     = 1'b1;
            dec_core.pc        = bus.i_pc;
            dec_core.rd        = instr[11:7];
            dec_core.rs1       = instr[19:15];
            dec_core.rs2       = instr[24:20];
            dec_core.funct3    = instr[14:12];
            dec_core.funct7_b5 = instr[30];
            if (instr[1:0] != 2'b11) begin
                dec_core.op      = OP_ILLEGAL;
                dec_core.illegal = 1'b1;
                dec_core.rd      = 5'd0;
            end else begin
                case (instr[6:0])
                    OPC_R:      dec_core.op = OP_ALU_R;
                    OPC_I_ALU: begin
                        dec_core.op = OP_ALU_I;
                        fmt         = FMT_I;
                    end
                    OPC_LOAD: begin
                        dec_core.op = OP_LOAD;
                        fmt         = FMT_I;
                    end
                    OPC_STORE: begin
                        dec_core.op = OP_STORE;
                        dec_core.rd = 5'd0;
                        fmt         = FMT_S;
                    end
                    OPC_BRANCH: begin
                        dec_core.op = OP_BRANCH;
                        dec_core.rd = 5'd0;
                        fmt         = FMT_B;
                    end
                    OPC_JAL: begin
                        dec_core.op = OP_JAL;
                        fmt         = FMT_J;
                    end
                    OPC_JALR: begin
                        dec_core.op = OP_JALR;
                        fmt         = FMT_I;
                    end
                    OPC_LUI: begin
                        dec_core.op = OP_LUI;
                        fmt         = FMT_U;
                    end
                    OPC_AUIPC: begin
                        dec_core.op = OP_AUIPC;
                        fmt         = FMT_U;
                    end
                    OPC_SYSTEM: begin
                        if (DECODE_SYSTEM) begin
                            dec_core.op = OP_SYSTEM;
                            fmt         = FMT_I;
                        end else begin
                            dec_core.op      = OP_ILLEGAL;
                            dec_core.illegal = 1'b1;
                            dec_core.rd      = 5'd0;
                        end
                    end
                    OPC_FENCE: begin
                        // Memory is in-order here, so FENCE retires as a valid no-op.
                        dec_core.op = OP_NOP;
                        fmt         = FMT_I;
                    end
                    default: begin
                        dec_core.op      = OP_ILLEGAL;
                        dec_core.illegal = 1'b1;
                        dec_core.rd      = 5'd0;
                    end
                endcase
            end
        end
    end

    imm_gen u_imm_gen (
        .instr_i (instr[31:7]),
        .fmt_i   (fmt),
        .imm_o   (imm)
    );

    // Merge the immediate into the decoded bundle.
    always_comb begin
        dec_full     = dec_core;
        dec_full.imm = imm;
    end

    // Load-use hazard: the load now in this stage's register feeds an operand of the incoming one.
    always_comb begin
        hazard = 1'b0;
        if (HAZARD_DETECT && out_q.valid && (out_q.op == OP_LOAD) && (out_q.rd != 5'd0)) begin
            hazard = (uses_rs1(dec_core.op) && (dec_core.rs1 == out_q.rd)) ||
                     (uses_rs2(dec_core.op) && (dec_core.rs2 == out_q.rd));
        end
    end

    // A flush redirects fetch itself, so a hazard under flush must not hold fetch.
    assign bus.o_fetch_stall = bus.i_pipeline_stall | (hazard & ~bus.i_flush);

    // Next-state priority: flush > downstream stall > hazard bubble > normal load.
    always_comb begin
        out_d = dec_full;
        if (bus.i_flush) begin
            out_d = DEC_BUBBLE;
        end else if (bus.i_pipeline_stall) begin
            out_d = out_q;
        end else if (hazard) begin
            out_d = DEC_BUBBLE;
        end
    end

    // Single output register bank; async reset to a bubble also clears the hazard source.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= DEC_BUBBLE;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.o_valid     = out_q.valid;
    assign bus.o_pc        = out_q.pc;
    assign bus.o_op        = out_q.op;
    assign bus.o_rd        = out_q.rd;
    assign bus.o_rs1       = out_q.rs1;
    assign bus.o_rs2       = out_q.rs2;
    assign bus.o_funct3    = out_q.funct3;
    assign bus.o_funct7_b5 = out_q.funct7_b5;
    assign bus.o_imm       = out_q.imm;
    assign bus.o_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: hand-computed vectors, immediate assertions.
module tb_decode;
    import riscv_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    decode_if bus ();

    decode #(
        .HAZARD_DETECT (1'b1),
        .DECODE_SYSTEM (1'b1)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        bus.i_instruction = ins;
        bus.i_pc          = pc;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.i_instruction    = 32'd0;
        bus.i_pc             = 32'd0;
        bus.i_pipeline_stall = 1'b0;
        bus.i_flush          = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_op", 32'(bus.o_op), 32'(OP_NOP));
        chk("rst_imm", bus.o_imm, 32'd0);
        chk("rst_pc", bus.o_pc, 32'd0);
        chk("rst_fstall", 32'(bus.o_fetch_stall), 32'd0);
        rst_n = 1'b1;

        // addi x1,x0,5
        drive(32'h00500093, 32'h00000100);
        #1;
        chk("addi_rs1_addr", 32'(bus.o_rs1_addr), 32'd0);
        chk("addi_rs2_addr", 32'(bus.o_rs2_addr), 32'd5);
        tick();
        chk("addi_valid", 32'(bus.o_valid), 32'd1);
        chk("addi_op", 32'(bus.o_op), 32'(OP_ALU_I));
        chk("addi_rd", 32'(bus.o_rd), 32'd1);
        chk("addi_rs1", 32'(bus.o_rs1), 32'd0);
        chk("addi_imm", bus.o_imm, 32'd5);
        chk("addi_pc", bus.o_pc, 32'h00000100);
        chk("addi_illegal", 32'(bus.o_illegal), 32'd0);

        // beq x0,x0,-4
        drive(32'hFE000EE3, 32'h00000104);
        tick();
        chk("beq_op", 32'(bus.o_op), 32'(OP_BRANCH));
        chk("beq_imm", bus.o_imm, 32'hFFFFFFFC);
        chk("beq_rd", 32'(bus.o_rd), 32'd0);

        // lui x5,0x12345
        drive(32'h123452B7, 32'h00000108);
        tick();
        chk("lui_op", 32'(bus.o_op), 32'(OP_LUI));
        chk("lui_imm", bus.o_imm, 32'h12345000);
        chk("lui_rd", 32'(bus.o_rd), 32'd5);

        // jal x1,8
        drive(32'h008000EF, 32'h0000010C);
        tick();
        chk("jal_op", 32'(bus.o_op), 32'(OP_JAL));
        chk("jal_imm", bus.o_imm, 32'd8);
        chk("jal_rd", 32'(bus.o_rd), 32'd1);

        // sw x2,4(x1): rd forced to 0, S immediate
        drive(32'h0020A223, 32'h00000110);
        tick();
        chk("sw_op", 32'(bus.o_op), 32'(OP_STORE));
        chk("sw_imm", bus.o_imm, 32'd4);
        chk("sw_rd", 32'(bus.o_rd), 32'd0);
        chk("sw_funct3", 32'(bus.o_funct3), 32'd2);

        // lw x2,0(x1) then add x3,x2,x1 -> one bubble
        drive(32'h0000A103, 32'h00000114);
        tick();
        chk("lw_op", 32'(bus.o_op), 32'(OP_LOAD));
        chk("lw_rd", 32'(bus.o_rd), 32'd2);
        drive(32'h001101B3, 32'h00000118);
        #1;
        chk("haz_fstall", 32'(bus.o_fetch_stall), 32'd1);
        tick();
        chk("haz_bubble_valid", 32'(bus.o_valid), 32'd0);
        chk("haz_bubble_op", 32'(bus.o_op), 32'(OP_NOP));
        chk("haz_fstall_clear", 32'(bus.o_fetch_stall), 32'd0);
        tick();
        chk("add_valid", 32'(bus.o_valid), 32'd1);
        chk("add_op", 32'(bus.o_op), 32'(OP_ALU_R));
        chk("add_rd", 32'(bus.o_rd), 32'd3);
        chk("add_rs1", 32'(bus.o_rs1), 32'd2);
        chk("add_rs2", 32'(bus.o_rs2), 32'd1);
        chk("add_pc", bus.o_pc, 32'h00000118);

        // lw x0,0(x1) then add x3,x0,x1 -> no stall
        drive(32'h0000A003, 32'h0000011C);
        tick();
        drive(32'h001001B3, 32'h00000120);
        #1;
        chk("x0_fstall", 32'(bus.o_fetch_stall), 32'd0);
        tick();
        chk("x0_add_valid", 32'(bus.o_valid), 32'd1);
        chk("x0_add_rd", 32'(bus.o_rd), 32'd3);

        // lw x2 then addi x5,x0,2: rs2 field equals 2 but is immediate, no stall
        drive(32'h0000A103, 32'h00000124);
        tick();
        drive(32'h00200293, 32'h00000128);
        #1;
        chk("irs2_fstall", 32'(bus.o_fetch_stall), 32'd0);
        tick();
        chk("irs2_valid", 32'(bus.o_valid), 32'd1);
        chk("irs2_rd", 32'(bus.o_rd), 32'd5);
        chk("irs2_imm", bus.o_imm, 32'd2);

        // Downstream stall for 3 cycles with changing inputs: outputs frozen
        bus.i_pipeline_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h123452B7 + 32'(i << 7), 32'h00000200 + 32'(i * 4));
            #1;
            chk("stall_fstall", 32'(bus.o_fetch_stall), 32'd1);
            tick();
            chk("stall_rd", 32'(bus.o_rd), 32'd5);
            chk("stall_imm", bus.o_imm, 32'd2);
            chk("stall_pc", bus.o_pc, 32'h00000128);
        end
        // Flush beats stall
        bus.i_flush = 1'b1;
        tick();
        chk("flush_valid", 32'(bus.o_valid), 32'd0);
        chk("flush_op", 32'(bus.o_op), 32'(OP_NOP));
        chk("flush_imm", bus.o_imm, 32'd0);
        chk("flush_pc", bus.o_pc, 32'd0);
        bus.i_flush          = 1'b0;
        bus.i_pipeline_stall = 1'b0;

        // Illegal encodings
        drive(32'hFFFFFFFF, 32'h00000300);
        tick();
        chk("ill1_valid", 32'(bus.o_valid), 32'd1);
        chk("ill1_illegal", 32'(bus.o_illegal), 32'd1);
        chk("ill1_op", 32'(bus.o_op), 32'(OP_ILLEGAL));
        chk("ill1_rd", 32'(bus.o_rd), 32'd0);
        drive(32'h00000001, 32'h00000304);
        tick();
        chk("ill2_valid", 32'(bus.o_valid), 32'd1);
        chk("ill2_illegal", 32'(bus.o_illegal), 32'd1);
        chk("ill2_op", 32'(bus.o_op), 32'(OP_ILLEGAL));

        // Zero word is a bubble
        drive(32'h00000000, 32'h00000308);
        tick();
        chk("zero_valid", 32'(bus.o_valid), 32'd0);
        chk("zero_illegal", 32'(bus.o_illegal), 32'd0);

        // Async reset in the middle of a hazard
        drive(32'h0000A103, 32'h00000400);
        tick();
        drive(32'h001101B3, 32'h00000404);
        #1;
        chk("mid_fstall", 32'(bus.o_fetch_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_valid), 32'd0);
        chk("arst_op", 32'(bus.o_op), 32'(OP_NOP));
        chk("arst_rd", 32'(bus.o_rd), 32'd0);
        chk("arst_pc", bus.o_pc, 32'd0);
        chk("arst_fstall", 32'(bus.o_fetch_stall), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(bus.o_valid), 32'd1);
        chk("post_rst_rd", 32'(bus.o_rd), 32'd3);
        chk("post_rst_op", 32'(bus.o_op), 32'(OP_ALU_R));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
